// File: rtl/acc_temporal_feeder_pkg.sv
// Shared types and constants for the temporal accumulator feeder.
// Holds the state encoding and the fp16 neutral element.
package acc_temporal_feeder_pkg;

  localparam int DEF_LANES = 16;
  localparam int DEF_DW    = 16;
  localparam int VEC_W     = DEF_LANES * DEF_DW;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

endpackage

// File: rtl/acc_beat_counter.sv
// Clearable up-counter with a full-width terminal flag.
// term is high when the next increment reaches limit.
module acc_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         term
);

  logic [W-1:0] cnt;

  // count accepted events; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // extra bit so limit = all-ones never wraps
  assign term = ({1'b0, cnt} + {{W{1'b0}}, 1'b1})
             == {1'b0, limit};

endmodule

// File: rtl/acc_temporal_feeder.sv
// Streams upstream fp16 vectors into the accumulator in groups.
// Zero-drives the data bus whenever no beat is presented.
module acc_temporal_feeder
  import acc_temporal_feeder_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int LEN_W = 8,
  parameter int GRP_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [GRP_W-1:0]    cfg_groups,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES*DW-1:0] s_vector,
  output logic                acc_in_valid,
  output logic [LANES*DW-1:0] acc_in_vector,
  output logic                acc_in_accum_done,
  input  logic                acc_out_valid,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int VW =
    (LANES == DEF_LANES && DW == DEF_DW)
      ? VEC_W : LANES * DW;

  localparam logic [VW-1:0] ZERO_VEC =
    {LANES{DW'(FP16_POS_ZERO)}};

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [GRP_W-1:0] grp_q;
  logic             aov_q;
  logic             accept;
  logic             start_ok;
  logic             res_hit;
  logic             beat_term;
  logic             grp_term;

  assign s_ready  = (state == STREAM);
  assign accept   = s_ready & s_valid;
  assign start_ok = (state == IDLE) & cfg_start
                  & (cfg_len != '0)
                  & (cfg_groups != '0);
  assign res_hit  = (state == WAIT_RES)
                  & acc_out_valid & ~aov_q;

  acc_beat_counter #(
    .W (LEN_W)
  ) u_beat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok | (accept & beat_term)),
    .inc   (accept),
    .limit (len_q),
    .term  (beat_term)
  );

  acc_beat_counter #(
    .W (GRP_W)
  ) u_grp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (res_hit),
    .limit (grp_q),
    .term  (grp_term)
  );

  // previous result-valid, for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aov_q <= 1'b0;
    end else begin
      aov_q <= acc_out_valid;
    end
  end

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      len_q             <= '0;
      grp_q             <= '0;
      acc_in_valid      <= 1'b0;
      acc_in_vector     <= ZERO_VEC;
      acc_in_accum_done <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      cfg_err           <= 1'b0;
    end else begin
      acc_in_valid      <= 1'b0;
      acc_in_vector     <= ZERO_VEC;
      acc_in_accum_done <= 1'b0;
      done              <= 1'b0;
      cfg_err           <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start_ok) begin
            len_q <= cfg_len;
            grp_q <= cfg_groups;
            busy  <= 1'b1;
            state <= STREAM;
          end else if (cfg_start) begin
            cfg_err <= 1'b1;
          end
        end
        (state == STREAM): begin
          if (accept) begin
            acc_in_valid  <= 1'b1;
            acc_in_vector <= s_vector;
            if (beat_term) begin
              acc_in_accum_done <= 1'b1;
              state             <= WAIT_RES;
            end
          end
        end
        (state == WAIT_RES): begin
          if (res_hit) begin
            if (grp_term) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= STREAM;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_temporal_feeder.sv
// Self-checking bench for acc_temporal_feeder.
// Random vectors and gaps checked against a job-level model.
module tb_acc_temporal_feeder;
  import acc_temporal_feeder_pkg::*;

  localparam int VW = VEC_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [7:0]    cfg_len;
  logic [7:0]    cfg_groups;
  logic          s_valid;
  logic          s_ready;
  logic [VW-1:0] s_vector;
  logic          acc_in_valid;
  logic [VW-1:0] acc_in_vector;
  logic          acc_in_accum_done;
  logic          acc_out_valid;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_busy, m_wait, m_prev_aov;
  int m_len, m_groups, m_beat, m_grp;
  int seen_beats, seen_ad, seen_done;

  always #5 clk = ~clk;

  acc_temporal_feeder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_len           (cfg_len),
    .cfg_groups        (cfg_groups),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_vector          (s_vector),
    .acc_in_valid      (acc_in_valid),
    .acc_in_vector     (acc_in_vector),
    .acc_in_accum_done (acc_in_accum_done),
    .acc_out_valid     (acc_out_valid),
    .busy              (busy),
    .done              (done),
    .cfg_err           (cfg_err)
  );

  task automatic chk(input string tag,
                     input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = 0;
    m_wait     = 0;
    m_prev_aov = 0;
    m_len      = 0;
    m_groups   = 0;
    m_beat     = 0;
    m_grp      = 0;
  endtask

  function automatic logic [VW-1:0] mk_vec(input int mode);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    if (mode == 1)
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h3C00;
    if (mode == 2)
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(i);
    return v;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, acc_in_valid, 0);
    chk({tag, "_vec"}, acc_in_vector, 0);
    chk({tag, "_ad"}, acc_in_accum_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_ready"}, s_ready, 0);
  endtask

  // one clock of stimulus, model update and output check
  task automatic step(input bit st, input int len,
                      input int grp, input bit v,
                      input logic [VW-1:0] vec,
                      input bit aov);
    bit e_v, e_ad, e_done, e_err;
    logic [VW-1:0] e_vec;
    cfg_start     = st;
    cfg_len       = len[7:0];
    cfg_groups    = grp[7:0];
    s_valid       = v;
    s_vector      = vec;
    acc_out_valid = aov;
    chk("s_ready", s_ready, m_busy && !m_wait);
    e_v = 0; e_ad = 0; e_done = 0; e_err = 0;
    e_vec = '0;
    if (!m_busy) begin
      if (st) begin
        if (len != 0 && grp != 0) begin
          m_busy = 1; m_wait = 0;
          m_len = len; m_groups = grp;
          m_beat = 0; m_grp = 0;
        end else begin
          e_err = 1;
        end
      end
    end else if (!m_wait) begin
      if (v) begin
        e_v = 1; e_vec = vec;
        m_beat++;
        if (m_beat == m_len) begin
          e_ad = 1; m_beat = 0; m_wait = 1;
        end
      end
    end else if (aov && !m_prev_aov) begin
      m_grp++;
      m_wait = 0;
      if (m_grp == m_groups) begin
        m_busy = 0; e_done = 1;
      end
    end
    m_prev_aov = aov;
    @(posedge clk);
    #1;
    chk("acc_in_valid", acc_in_valid, e_v);
    chk("acc_in_vector", acc_in_vector, e_vec);
    chk("accum_done", acc_in_accum_done, e_ad);
    chk("busy", busy, m_busy);
    chk("done", done, e_done);
    chk("cfg_err", cfg_err, e_err);
    if (acc_in_valid) seen_beats++;
    if (acc_in_accum_done) seen_ad++;
    if (done) seen_done++;
    cfg_start = 0;
  endtask

  task automatic run_job(input int len, input int grp,
                         input int gap, input bit rnd_gap,
                         input int hold, input int vmode,
                         input bit poke);
    int cyc, g;
    seen_beats = 0; seen_ad = 0; seen_done = 0;
    step(1, len, grp, 0, '0, 0);
    cyc = 0;
    while (m_busy && cyc < 5000) begin
      if (!m_wait) begin
        g = rnd_gap ? $urandom_range(gap, 0) : gap;
        if (m_beat != 0)
          for (int k = 0; k < g; k++) step(0, 0, 0, 0, '0, 0);
        step(poke && cyc == 0, 7, 9, 1, mk_vec(vmode), 0);
      end else begin
        step(0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, '0, 0);
        for (int k = 0; k < hold; k++) step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 0);
      end
      cyc++;
    end
    chk("job_bound", cyc < 5000, 1);
    chk("beats", seen_beats, len * grp);
    chk("accum_cnt", seen_ad, grp);
    chk("done_cnt", seen_done, 1);
  endtask

  initial begin
    rst_n = 0;
    cfg_start = 0; cfg_len = 0; cfg_groups = 0;
    s_valid = 0; s_vector = '0; acc_out_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    rst_n = 1;

    // len 4, one group, back-to-back 1.0 vectors
    run_job(4, 1, 0, 0, 1, 1, 0);
    // len 3, two groups, 2-cycle gaps
    run_job(3, 2, 2, 0, 1, 0, 0);
    // len 1, three groups, result held 3 cycles
    run_job(1, 3, 0, 0, 3, 0, 0);

    // zero length / zero groups rejected
    step(1, 0, 2, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    step(1, 3, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);

    // cfg_start while busy ignored, len 4 governs
    run_job(4, 1, 1, 0, 1, 0, 1);

    // async reset mid-group after 2 of 4 beats
    step(1, 4, 1, 0, '0, 0);
    step(0, 0, 0, 1, mk_vec(0), 0);
    step(0, 0, 0, 1, mk_vec(0), 0);
    #2;
    rst_n = 0;
    #1;
    all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    seen_done = 0;
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    chk("no_done_after_rst", seen_done, 0);
    run_job(2, 1, 0, 0, 1, 0, 0);

    // lane ordering
    step(1, 1, 1, 0, '0, 0);
    step(0, 0, 0, 1, mk_vec(2), 0);
    chk("lane15", acc_in_vector[255:240], 16'h000F);
    chk("lane0", acc_in_vector[15:0], 16'h0000);
    chk("lane1", acc_in_vector[31:16], 16'h0001);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 0);

    // full-width length, no wrap
    run_job(255, 1, 0, 0, 1, 0, 0);

    // randomized jobs
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(6, 1), $urandom_range(3, 1),
              3, 1, $urandom_range(3, 1), 0, j[0]);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_temporal_feeder.md
Name: acc_temporal_feeder

Overview:
- Producer-side sequencer for the temporal fp16 accumulator.
- Accepts 256-bit fp16 vectors (16 lanes) from an upstream buffer over a valid/ready handshake.
- Streams them into the accumulator in groups of cfg_len vectors and marks the last beat of each group with accum_done.
- Waits for the accumulator's result pulse before starting the next group; reports completion after cfg_groups groups.

Parameters:
- LANES, 16, number of fp16 lanes per vector.
- DW, 16, bits per lane; vector width is LANES*DW (256 by default).
- LEN_W, 8, width of cfg_len (vectors per group).
- GRP_W, 8, width of cfg_groups (number of groups).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle pulse; latches cfg_len and cfg_groups and starts a job.
- cfg_len  input  LEN_W  vectors per accumulation group; must be ≥1.
- cfg_groups  input  GRP_W  groups per job; must be ≥1.
- s_valid  input  1  upstream vector valid.
- s_ready  output  1  feeder can accept an upstream vector.
- s_vector  input  LANES*DW  upstream fp16 vector.
- acc_in_valid  output  1  vector presented to the accumulator.
- acc_in_vector  output  LANES*DW  vector to the accumulator.
- acc_in_accum_done  output  1  last beat of the current group.
- acc_out_valid  input  1  accumulator result-valid pulse.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse when the job completes.
- cfg_err  output  1  one-cycle pulse when cfg_start arrives with a zero length or zero group count.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset is asynchronous and active-low. Reset mid-job abandons the job, and no done pulse follows.

States:
- IDLE -> STREAM on cfg_start with cfg_len≠0 and cfg_groups≠0. Latch both values, clear beat_cnt and grp_cnt, set busy.
- If cfg_start arrives with either field 0: pulse cfg_err next cycle and stay in IDLE.
- STREAM:
  - s_ready=1 combinationally while in STREAM.
  - On s_valid&s_ready, register s_vector onto acc_in_vector and set acc_in_valid=1 the next cycle (1-cycle latency) and increment beat_cnt.
  - When the accepted beat is number cfg_len of the group, set acc_in_accum_done=1 in the same output cycle as that beat, clear beat_cnt, and go to WAIT_RES.
  - With no accepted beat, the next cycle has acc_in_valid=0, acc_in_accum_done=0 and acc_in_vector all zeros.
  - Zero-drive is mandatory. The accumulator lanes consume their data input regardless of valid, and +0.0 (0x0000) is the neutral value.
- WAIT_RES:
  - s_ready=0; outputs held at valid=0, done=0, vector=0.
  - On acc_out_valid=1, increment grp_cnt.
  - If grp_cnt+1 == cfg_groups: go to IDLE, pulse done for one cycle, and drop busy in that same cycle.
  - Otherwise go back to STREAM.
- acc_out_valid outside WAIT_RES is ignored.
- cfg_start while busy is ignored; the latched config is unchanged and cfg_err is not pulsed.

Boundary conditions:
- cfg_len=1: every accepted beat carries accum_done.
- Back-to-back s_valid: one beat per cycle, no bubbles inside a group.
- Counters compare at full width, so cfg_len=2^LEN_W−1 is supported and there is no wrap.
- acc_out_valid asserted for multiple cycles counts once only: it is edge-qualified in WAIT_RES, and the state exits on the first cycle.
- Data is passed through bit-exact; no arithmetic on vector contents.

Decomposition:
- Shared package holds:
  - localparam VEC_W = LANES*DW;
  - the FP16 positive-zero constant 16'h0000;
  - the state encoding IDLE=2'd0, STREAM=2'd1, WAIT_RES=2'd2.
- One sub-module, acc_beat_counter, is natural: a loadable up-counter with a terminal flag, instantiated for beat_cnt and for grp_cnt.
- Output registering and the FSM stay in the top module.

Test Plan:
- cfg_len=4, cfg_groups=1; feed vectors with every lane 16'h3C00 (1.0) back-to-back -> acc_in_valid high for 4 consecutive cycles starting 1 cycle after the first s_valid&s_ready; accum_done only on beat 4; s_ready=0 until acc_out_valid is pulsed; then done pulses once and busy falls.
- cfg_len=3, cfg_groups=2; insert s_valid gaps of 2 cycles -> during gaps acc_in_vector==0 and acc_in_valid==0; exactly 6 beats forwarded; accum_done on beats 3 and 6; second group starts only after the first acc_out_valid.
- cfg_len=1, cfg_groups=3; respond to each group with acc_out_valid held 3 cycles -> 3 beats, each carrying accum_done; grp_cnt advances once per group; done after the 3rd response.
- cfg_start with cfg_len=0 -> cfg_err pulses once, busy stays 0, s_ready stays 0; cfg_start while busy -> ignored, original cfg_len=4 still governs.
- Assert rst_n low mid-group after 2 of 4 beats -> all outputs 0 asynchronously; after release, state is IDLE, no done; a new job with cfg_len=2 runs cleanly.
- Lane ordering check: s_vector with lane i = 16'h0000+i -> acc_in_vector is bit-identical, lane 15 in bits [255:240].
